mult_share_arb: RTL and testbench
=================================

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 The block SHALL have this parameter: NREQ, 4, number of requesters sharing one 4x4 multiplier (legal 2..8).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: req_valid  input  NREQ  per-requester operand-valid.
REQ-006 Port: req_x  input  4*NREQ  multiplicand; requester i uses bits [4i+3:4i].
REQ-007 Port: req_y  input  4*NREQ  multiplier; requester i uses bits [4i+3:4i].
REQ-008 Port: req_ready  output  NREQ  one-hot accept strobe.
REQ-009 Port: rsp_valid  output  1  result valid.
REQ-010 Port: rsp_ready  input  1  consumer accepts result.
REQ-011 Port: rsp_o  output  8  unsigned product x*y.
REQ-012 Port: rsp_id  output  3  index of the requester that owns rsp_o.
REQ-013 Port: done_cnt  output  8  count of completed responses, wraps 255->0.

Function
REQ-014 The block SHALL contain exactly one instance of the team's 4-bit multiplier and SHALL feed it only from internal operand registers.
REQ-015 FSM states SHALL be IDLE, CALC and DONE.
REQ-016 In IDLE with any req_valid set, the grant SHALL go to the first set bit searched from rr_ptr upward, modulo NREQ.
REQ-017 req_ready SHALL be combinational, asserted only in IDLE, only on the granted bit, and at most one bit high.
REQ-018 On the grant cycle the block SHALL capture x, y and the grant index into operand registers and move to CALC.
REQ-019 In IDLE with no req_valid set, the state and all registers SHALL hold.
REQ-020 In CALC the block SHALL register the multiplier output into rsp_o and the captured index into rsp_id, set rsp_valid, and move to DONE.
REQ-021 Latency SHALL be exactly 2 cycles: an accept at edge t gives rsp_valid=1 after edge t+2.
REQ-022 In DONE, rsp_valid, rsp_o and rsp_id SHALL stay stable until a cycle with rsp_ready=1.
REQ-023 On a DONE cycle with rsp_ready=1, the block SHALL on the next edge:
  - clear rsp_valid;
  - set rr_ptr to (grant index+1) mod NREQ;
  - increment done_cnt, modulo 256;
  - return to IDLE.
REQ-024 The block SHALL accept no new request in CALC or DONE; minimum issue interval SHALL be 3 cycles.
REQ-025 rsp_ready while rsp_valid=0 SHALL have no effect.
REQ-026 A requester deasserting req_valid before it is granted SHALL lose nothing and SHALL need no grant.
REQ-027 Operands SHALL be sampled only on the accept cycle; later changes to req_x and req_y SHALL NOT affect the result.
REQ-028 rsp_o SHALL equal the unsigned product of the 4-bit operands, range 0..225, with no truncation.
REQ-029 Requesters at index NREQ and above SHALL not exist; rsp_id bits above the index width SHALL read 0.

Reset
REQ-030 With rst=1 at a rising edge, the block SHALL set:
  - state to IDLE;
  - rr_ptr, rsp_o, rsp_id and done_cnt to 0;
  - rsp_valid to 0.
REQ-031 During rst=1, req_ready SHALL be all-zero.
REQ-032 Reset in any state, including mid-CALC or in DONE, SHALL discard the operation in flight; its result SHALL never appear.
REQ-033 Reset SHALL take priority over every simultaneous handshake.

Verification
REQ-034 Single request: req_valid=0001, x0=15, y0=15, rsp_ready=1 -> req_ready=0001 for one cycle; 2 cycles later rsp_o=225, rsp_id=0; done_cnt=1.
REQ-035 Contention after reset: all four valid with (x,y)=(3,5),(7,7),(0,9),(12,10), rsp_ready=1 -> grant order 0,1,2,3 with rsp_o=15,49,0,120; grants 3 cycles apart.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in DONE with rsp_o=42 -> rsp_o, rsp_id and rsp_valid stable; req_ready=0 throughout; release gives one completion.
REQ-037 Round-robin wrap: after a grant to 2, req_valid=1010 -> grant 3, then grant 1.
REQ-038 Reset mid-CALC with x=9, y=9: rst=1 for one cycle -> rsp_valid=0, done_cnt=0, rr_ptr=0; no 81 is ever output.
REQ-039 Operand change after accept: x0 changes 6->2 the cycle after accept with y0=4 -> rsp_o=24.

Source files
------------

// File: rtl/mult_share_arb.sv
// Round-robin arbiter that time-shares one 4x4 unsigned multiplier among NREQ requesters.
// Each accepted request runs IDLE -> CALC -> DONE and holds its result until the consumer takes it.

module mul4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    assign p = {4'b0, a} * {4'b0, b};
endmodule

module mult_share_arb #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_x,
    input  logic [4*NREQ-1:0] req_y,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_o,
    output logic [2:0]        rsp_id,
    output logic [7:0]        done_cnt
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state;
    logic [IDW-1:0]         rr_ptr;
    logic [IDW-1:0]         gnt_idx;
    logic [IDW-1:0]         op_id;
    logic [IDW-1:0]         ptr_next;
    logic                   gnt_any;
    logic [3:0]             op_x;
    logic [3:0]             op_y;
    logic [7:0]             prod;
    logic [NREQ-1:0][3:0]   x_arr;
    logic [NREQ-1:0][3:0]   y_arr;

    assign x_arr = req_x;
    assign y_arr = req_y;

    // Walk downward so the requester closest to rr_ptr overwrites the others.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && gnt_any)
            req_ready[gnt_idx] = 1'b1;
    end

    assign ptr_next = (op_id == IDW'(NREQ - 1)) ? '0 : op_id + 1'b1;

    // The multiplier only ever sees the captured operands, never the live request buses.
    mul4 u_mul (
        .a (op_x),
        .b (op_y),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_x      <= '0;
            op_y      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_o     <= '0;
            rsp_id    <= '0;
            done_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    op_x  <= x_arr[gnt_idx];
                    op_y  <= y_arr[gnt_idx];
                    op_id <= gnt_idx;
                    state <= CALC;
                end
                CALC: begin
                    rsp_o     <= prod;
                    rsp_id    <= 3'(op_id);
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rr_ptr    <= ptr_next;
                    done_cnt  <= done_cnt + 8'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: directed scenarios plus a randomized run against a transaction-level model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.

module tb_mult_share_arb;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [4*NREQ-1:0] req_x = '0;
    logic [4*NREQ-1:0] req_y = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [7:0]        rsp_o;
    logic [2:0]        rsp_id;
    logic [7:0]        done_cnt;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    mult_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_o     (rsp_o),
        .rsp_id    (rsp_id),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a grant; returns at the falling edge of the grant cycle.
    task automatic wait_grant(input int limit, output logic [NREQ-1:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g  = req_ready;
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Reference arbitration rule: first requester at or after ptr, wrapping.
    function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] mask, input int ptr);
        logic [NREQ-1:0] r;
        r = '0;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (mask[i] && r == '0) r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        n_chk++; if (req_ready !== 4'h0) $display("FAIL reset_ready got=%b exp=0000", req_ready); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
        n_chk++; if (rsp_o !== 8'd0) $display("FAIL reset_rsp_o got=%0d exp=0", rsp_o); else n_pass++;
        n_chk++; if (rsp_id !== 3'd0) $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); else n_pass++;
        n_chk++; if (done_cnt !== 8'd0) $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); else n_pass++;
        n_chk++; if (req_ready !== 4'h0) $display("FAIL reset_ready_hold got=%b exp=0000", req_ready); else n_pass++;
        tick();
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g;
        bit ok;
        int t0;
        do_reset();
        req_x[3:0] = 4'd15;
        req_y[3:0] = 4'd15;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        wait_grant(10, g, ok);
        n_chk++; if (!ok || g !== 4'b0001) $display("FAIL single_grant got=%b exp=0001", g); else n_pass++;
        t0 = cyc;
        tick();
        req_valid = '0;
        @(negedge clk);
        n_chk++; if (req_ready !== 4'h0) $display("FAIL single_ready_once got=%b exp=0000", req_ready); else n_pass++;
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", rsp_valid); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b1 || cyc - t0 != 2) $display("FAIL single_latency valid=%b cycles=%0d exp=2", rsp_valid, cyc - t0); else n_pass++;
        n_chk++; if (rsp_o !== 8'd225) $display("FAIL single_rsp_o got=%0d exp=225", rsp_o); else n_pass++;
        n_chk++; if (rsp_id !== 3'd0) $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL single_valid_clear got=%b exp=0", rsp_valid); else n_pass++;
        n_chk++; if (done_cnt !== 8'd1) $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); else n_pass++;
    endtask

    task automatic test_contention();
        int exp_p[4] = '{15, 49, 0, 120};
        int last = -1;
        int got  = 0;
        logic [NREQ-1:0] gbit;
        do_reset();
        req_x = {4'd12, 4'd0, 4'd7, 4'd3};
        req_y = {4'd10, 4'd9, 4'd7, 4'd5};
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            gbit = req_ready;
            if (gbit != '0) begin
                n_chk++; if (gbit !== pick(4'hF, got)) $display("FAIL contention_grant got=%b exp_idx=%0d", gbit, got); else n_pass++;
                if (last >= 0) begin
                    n_chk++; if (cyc - last != 3) $display("FAIL contention_interval got=%0d exp=3", cyc - last); else n_pass++;
                end
                last = cyc;
            end
            if (rsp_valid) begin
                n_chk++; if (rsp_o !== 8'(exp_p[got]) || rsp_id !== 3'(got))
                    $display("FAIL contention_rsp got=%0d/id%0d exp=%0d/id%0d", rsp_o, rsp_id, exp_p[got], got);
                else n_pass++;
                got++;
            end
            tick();
            req_valid = req_valid & ~gbit;
        end
        n_chk++; if (got != 4) $display("FAIL contention_timeout got=%0d responses exp=4", got); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] g;
        bit ok;
        do_reset();
        req_x[7:4] = 4'd6;
        req_y[7:4] = 4'd7;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        wait_grant(10, g, ok);
        n_chk++; if (!ok || g !== 4'b0010) $display("FAIL bp_grant got=%b exp=0010", g); else n_pass++;
        tick();
        req_valid = 4'hF;
        wait_rsp(10, ok);
        n_chk++; if (!ok) $display("FAIL bp_rsp_timeout got=none exp=rsp_valid"); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_chk++; if (rsp_valid !== 1'b1 || rsp_o !== 8'd42 || rsp_id !== 3'd1 || req_ready !== 4'h0)
                $display("FAIL bp_hold v=%b o=%0d id=%0d rdy=%b exp=1/42/1/0000", rsp_valid, rsp_o, rsp_id, req_ready);
            else n_pass++;
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b1 || done_cnt !== 8'd0) $display("FAIL bp_release v=%b cnt=%0d exp=1/0", rsp_valid, done_cnt); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b0 || done_cnt !== 8'd1) $display("FAIL bp_complete v=%b cnt=%0d exp=0/1", rsp_valid, done_cnt); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (done_cnt !== 8'd1) $display("FAIL bp_single_completion cnt=%0d exp=1", done_cnt); else n_pass++;
    endtask

    task automatic test_rr_wrap();
        logic [NREQ-1:0] g;
        bit ok;
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        wait_grant(10, g, ok);
        n_chk++; if (!ok || g !== 4'b0100) $display("FAIL wrap_first got=%b exp=0100", g); else n_pass++;
        tick();
        req_valid = '0;
        wait_rsp(10, ok);
        tick();
        req_valid = 4'b1010;
        wait_grant(10, g, ok);
        n_chk++; if (!ok || g !== 4'b1000) $display("FAIL wrap_second got=%b exp=1000", g); else n_pass++;
        tick();
        req_valid = 4'b0010;
        wait_rsp(10, ok);
        tick();
        wait_grant(10, g, ok);
        n_chk++; if (!ok || g !== 4'b0010) $display("FAIL wrap_third got=%b exp=0010", g); else n_pass++;
        tick();
        req_valid = '0;
        wait_rsp(10, ok);
        n_chk++; if (!ok || rsp_id !== 3'd1) $display("FAIL wrap_rsp_id got=%0d exp=1", rsp_id); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_calc();
        logic [NREQ-1:0] g;
        bit ok;
        bit saw81 = 1'b0;
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        wait_grant(10, g, ok);
        tick();
        req_valid = '0;
        wait_rsp(10, ok);
        tick();
        req_x[3:0] = 4'd9;
        req_y[3:0] = 4'd9;
        req_valid = 4'b0001;
        wait_grant(10, g, ok);
        n_chk++; if (!ok || g !== 4'b0001) $display("FAIL midcalc_grant got=%b exp=0001", g); else n_pass++;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || rsp_o == 8'd81) saw81 = 1'b1;
            tick();
        end
        n_chk++; if (saw81) $display("FAIL midcalc_discard got=valid_or_81 exp=none"); else n_pass++;
        @(negedge clk);
        n_chk++; if (done_cnt !== 8'd0) $display("FAIL midcalc_done_cnt got=%0d exp=0", done_cnt); else n_pass++;
        tick();
        req_valid = 4'hF;
        wait_grant(10, g, ok);
        n_chk++; if (!ok || g !== 4'b0001) $display("FAIL midcalc_ptr_reset got=%b exp=0001", g); else n_pass++;
        tick();
        req_valid = '0;
        wait_rsp(10, ok);
        tick();
    endtask

    task automatic test_operand_change();
        logic [NREQ-1:0] g;
        bit ok;
        do_reset();
        rsp_ready = 1'b1;
        req_x[3:0] = 4'd6;
        req_y[3:0] = 4'd4;
        req_valid = 4'b0001;
        wait_grant(10, g, ok);
        tick();
        req_valid = '0;
        req_x[3:0] = 4'd2;
        wait_rsp(10, ok);
        n_chk++; if (!ok || rsp_o !== 8'd24) $display("FAIL operand_hold got=%0d exp=24", rsp_o); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int ptr_m = 0;
        bit busy = 1'b0;
        int age = 0;
        int eid = 0;
        int eprod = 0;
        int edone = 0;
        logic [NREQ-1:0] exp_rdy;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                req_x[4*i +: 4] = 4'($urandom);
                req_y[4*i +: 4] = 4'($urandom);
            end
            @(negedge clk);
            exp_rdy = busy ? '0 : pick(req_valid, ptr_m);
            n_chk++; if (req_ready !== exp_rdy) $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); else n_pass++;
            n_chk++; if (rsp_valid !== (busy && age == 2)) $display("FAIL rand_valid c=%0d got=%b exp=%b", c, rsp_valid, busy && age == 2); else n_pass++;
            if (busy && age == 2) begin
                n_chk++; if (rsp_o !== 8'(eprod) || rsp_id !== 3'(eid))
                    $display("FAIL rand_rsp c=%0d got=%0d/id%0d exp=%0d/id%0d", c, rsp_o, rsp_id, eprod, eid);
                else n_pass++;
            end
            n_chk++; if (done_cnt !== 8'(edone)) $display("FAIL rand_done_cnt c=%0d got=%0d exp=%0d", c, done_cnt, edone % 256); else n_pass++;
            if (!busy && exp_rdy != '0) begin
                for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) eid = i;
                eprod = int'(req_x[4*eid +: 4]) * int'(req_y[4*eid +: 4]);
                busy = 1'b1;
                age = 1;
            end else if (busy && age == 1) begin
                age = 2;
            end else if (busy && age == 2 && rsp_ready) begin
                busy = 1'b0;
                ptr_m = (eid + 1) % NREQ;
                edone++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_rr_wrap();
        test_reset_mid_calc();
        test_operand_change();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
